// File: rtl/soc_system_pio_pkg.sv
// Shared constants and helpers for the soc_system PIO/GPIO block.
package soc_system_pio_pkg;

  localparam logic [2:0] ADDR_DATA     = 3'd0;
  localparam logic [2:0] ADDR_DIR      = 3'd1;
  localparam logic [2:0] ADDR_IRQ_MASK = 3'd2;
  localparam logic [2:0] ADDR_EDGE_CAP = 3'd3;
  localparam logic [2:0] ADDR_OUTSET   = 3'd4;
  localparam logic [2:0] ADDR_OUTCLEAR = 3'd5;

  localparam int EDGE_RISING  = 0;
  localparam int EDGE_FALLING = 1;
  localparam int EDGE_ANY     = 2;

  // Clears every bit at or above w so narrow registers read back zero-extended.
  function automatic logic [31:0] zext32(input logic [31:0] v, input int unsigned w);
    logic [31:0] m;
    m = (w >= 32) ? 32'hFFFF_FFFF : ((32'd1 << w) - 32'd1);
    return v & m;
  endfunction

endpackage

// File: rtl/soc_system_pio_sync.sv
// Three-flop input chain: s2 is the synchronised pin value, s2 vs s3 gives the edge.
module soc_system_pio_sync
  import soc_system_pio_pkg::*;
#(
  parameter int W         = 8,
  parameter int EDGE_TYPE = EDGE_RISING
) (
  input  logic         clk,
  input  logic         reset,
  input  logic [W-1:0] in_port,
  output logic [W-1:0] in_sync,
  output logic [W-1:0] detect
);

  logic [W-1:0] s1, s2, s3;

  always_ff @(posedge clk) begin
    if (reset) begin
      s1 <= '0;
      s2 <= '0;
      s3 <= '0;
    end else begin
      s1 <= in_port;
      s2 <= s1;
      s3 <= s2;
    end
  end

  assign in_sync = s2;

  always_comb begin
    detect = s2 ^ s3;
    case (EDGE_TYPE)
      EDGE_RISING:  detect = s2 & ~s3;
      EDGE_FALLING: detect = ~s2 & s3;
      default:      detect = s2 ^ s3;
    endcase
  end

endmodule

// File: rtl/soc_system_pio_gpio.sv
// Avalon-MM GPIO port: direction, set/clear, synchronised inputs, edge capture, masked irq.
module soc_system_pio_gpio
  import soc_system_pio_pkg::*;
#(
  parameter int                    DATA_WIDTH  = 8,
  parameter logic [DATA_WIDTH-1:0] RESET_VALUE = '0,
  parameter logic [DATA_WIDTH-1:0] DIR_RESET   = '0,
  parameter int                    EDGE_TYPE   = EDGE_RISING
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic [2:0]            address,
  input  logic                  chipselect,
  input  logic                  write_n,
  input  logic [31:0]           writedata,
  output logic [31:0]           readdata,
  input  logic [DATA_WIDTH-1:0] in_port,
  output logic [DATA_WIDTH-1:0] out_port,
  output logic [DATA_WIDTH-1:0] oe,
  output logic                  irq
);

  logic [DATA_WIDTH-1:0] data_out, dir, irq_mask, edge_capture;
  logic [DATA_WIDTH-1:0] in_sync, detect, wd, clr_mask, rd_word;
  logic                  wr;
  logic                  unused_wd;

  assign wr        = chipselect & ~write_n;
  assign wd        = writedata[DATA_WIDTH-1:0];
  assign unused_wd = ^{1'b0, writedata};
  assign clr_mask  = (wr && address == ADDR_EDGE_CAP) ? wd : '0;

  soc_system_pio_sync #(
    .W         (DATA_WIDTH),
    .EDGE_TYPE (EDGE_TYPE)
  ) u_sync (
    .clk     (clk),
    .reset   (reset),
    .in_port (in_port),
    .in_sync (in_sync),
    .detect  (detect)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      data_out     <= RESET_VALUE;
      dir          <= DIR_RESET;
      irq_mask     <= '0;
      edge_capture <= '0;
    end else begin
      if (wr) begin
        case (address)
          ADDR_DATA:     data_out <= wd;
          ADDR_DIR:      dir      <= wd;
          ADDR_IRQ_MASK: irq_mask <= wd;
          ADDR_OUTSET:   data_out <= data_out | wd;
          ADDR_OUTCLEAR: data_out <= data_out & ~wd;
          default: ;
        endcase
      end
      // A fresh edge beats a simultaneous write-1-to-clear of the same bit.
      edge_capture <= (edge_capture & ~clr_mask) | detect;
    end
  end

  always_comb begin
    rd_word = '0;
    case (address)
      ADDR_DATA:     rd_word = (dir & data_out) | (~dir & in_sync);
      ADDR_DIR:      rd_word = dir;
      ADDR_IRQ_MASK: rd_word = irq_mask;
      ADDR_EDGE_CAP: rd_word = edge_capture;
      default:       rd_word = '0;
    endcase
  end

  assign readdata = zext32(32'(rd_word), DATA_WIDTH);
  assign out_port = data_out;
  assign oe       = dir;
  assign irq      = |(edge_capture & irq_mask);

endmodule

// File: tb/tb_soc_system_pio_gpio.sv
// Two instances (8-bit rising, 32-bit any-edge) checked against a register-level model.
module tb_soc_system_pio_gpio;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [2:0]  addr = '0;
  logic        cs0 = 1'b0, cs1 = 1'b0, wn = 1'b1;
  logic [31:0] wdata = '0;
  logic [31:0] rd0, rd1;
  logic [7:0]  in0 = '0, out0, oe0;
  logic [31:0] in1 = '0, out1, oe1;
  logic        irq0, irq1;

  int n_cmp = 0, n_err = 0;

  localparam logic [31:0] RV1 = 32'h1234_5678;
  localparam logic [31:0] DR1 = 32'h0000_FFFF;

  always #5 clk = ~clk;

  soc_system_pio_gpio #(.DATA_WIDTH(8), .RESET_VALUE(8'hA5), .DIR_RESET(8'h0F), .EDGE_TYPE(0)) u_dut0 (
    .clk(clk), .reset(rst), .address(addr), .chipselect(cs0), .write_n(wn),
    .writedata(wdata), .readdata(rd0), .in_port(in0), .out_port(out0), .oe(oe0), .irq(irq0));

  soc_system_pio_gpio #(.DATA_WIDTH(32), .RESET_VALUE(RV1), .DIR_RESET(DR1), .EDGE_TYPE(2)) u_dut1 (
    .clk(clk), .reset(rst), .address(addr), .chipselect(cs1), .write_n(wn),
    .writedata(wdata), .readdata(rd1), .in_port(in1), .out_port(out1), .oe(oe1), .irq(irq1));

  // Model state: register contents plus the pin values seen at the last three edges.
  logic [31:0] m_data[2], m_dir[2], m_im[2], m_ec[2], m_p1[2], m_p2[2], m_p3[2];
  logic [31:0] m_msk[2] = '{32'h0000_00FF, 32'hFFFF_FFFF};
  logic [31:0] m_rv[2]  = '{32'h0000_00A5, RV1};
  logic [31:0] m_dr[2]  = '{32'h0000_000F, DR1};
  int          m_et[2]  = '{0, 2};

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  function automatic logic [31:0] m_edges(input int k);
    case (m_et[k])
      0:       return m_p2[k] & ~m_p3[k];
      1:       return ~m_p2[k] & m_p3[k];
      default: return m_p2[k] ^ m_p3[k];
    endcase
  endfunction

  function automatic logic [31:0] m_read(input int k, input logic [2:0] a);
    case (a)
      3'd0:    return ((m_dir[k] & m_data[k]) | (~m_dir[k] & m_p2[k])) & m_msk[k];
      3'd1:    return m_dir[k];
      3'd2:    return m_im[k];
      3'd3:    return m_ec[k];
      default: return 32'h0;
    endcase
  endfunction

  task automatic model_step();
    logic [31:0] det, wd, clr, pin;
    logic        we;
    for (int k = 0; k < 2; k++) begin
      pin = (k == 0) ? {24'h0, in0} : in1;
      if (rst) begin
        m_data[k] = m_rv[k]; m_dir[k] = m_dr[k]; m_im[k] = '0; m_ec[k] = '0;
        m_p1[k] = '0; m_p2[k] = '0; m_p3[k] = '0;
      end else begin
        det = m_edges(k) & m_msk[k];
        we  = ((k == 0) ? cs0 : cs1) && !wn;
        wd  = wdata & m_msk[k];
        clr = '0;
        if (we) begin
          case (addr)
            3'd0: m_data[k] = wd;
            3'd1: m_dir[k]  = wd;
            3'd2: m_im[k]   = wd;
            3'd3: clr       = wd;
            3'd4: m_data[k] = m_data[k] | wd;
            3'd5: m_data[k] = m_data[k] & ~wd;
            default: ;
          endcase
        end
        m_ec[k] = (m_ec[k] & ~clr) | det;
        m_p3[k] = m_p2[k]; m_p2[k] = m_p1[k]; m_p1[k] = pin & m_msk[k];
      end
    end
  endtask

  task automatic check_all();
    chk("out0", {24'h0, out0}, m_data[0]);
    chk("oe0",  {24'h0, oe0},  m_dir[0]);
    chk("irq0", {31'h0, irq0}, {31'h0, |(m_ec[0] & m_im[0])});
    chk("rd0",  rd0, m_read(0, addr));
    chk("out1", out1, m_data[1]);
    chk("oe1",  oe1,  m_dir[1]);
    chk("irq1", {31'h0, irq1}, {31'h0, |(m_ec[1] & m_im[1])});
    chk("rd1",  rd1, m_read(1, addr));
  endtask

  task automatic cyc(input int n = 1);
    for (int i = 0; i < n; i++) begin
      @(posedge clk);
      model_step();
      #1;
      check_all();
    end
  endtask

  task automatic wr(input int k, input logic [2:0] a, input logic [31:0] d);
    addr = a; wdata = d; wn = 1'b0; cs0 = (k == 0); cs1 = (k == 1);
    cyc();
    wn = 1'b1; cs0 = 1'b0; cs1 = 1'b0;
  endtask

  task automatic rdchk(input string tag, input int k, input logic [2:0] a, input logic [31:0] e);
    addr = a;
    #1;
    chk(tag, (k == 0) ? rd0 : rd1, e);
  endtask

  initial begin
    cyc(2);
    rst = 1'b0;
    chk("rst_out0", {24'h0, out0}, 32'hA5);
    chk("rst_oe0",  {24'h0, oe0},  32'h0F);

    // Reset mid-operation overrides a concurrent OUTSET
    wr(0, 3'd0, 32'h3C);
    rst = 1'b1; addr = 3'd4; wdata = 32'hFF; wn = 1'b0; cs0 = 1'b1;
    cyc();
    rst = 1'b0; wn = 1'b1; cs0 = 1'b0;
    chk("mid_rst_out", {24'h0, out0}, 32'hA5);
    chk("mid_rst_oe",  {24'h0, oe0},  32'h0F);
    chk("mid_rst_irq", {31'h0, irq0}, 32'h0);
    rdchk("mid_rst_ec", 0, 3'd3, 32'h0);

    // Set / clear
    wr(0, 3'd0, 32'h00);
    wr(0, 3'd4, 32'h81);
    wr(0, 3'd5, 32'h01);
    chk("setclr_out", {24'h0, out0}, 32'h80);
    rdchk("rd_outset", 0, 3'd4, 32'h0);
    rdchk("rd_outclr", 0, 3'd5, 32'h0);

    // Mixed DATA read
    wr(0, 3'd1, 32'hF0);
    wr(0, 3'd0, 32'hAA);
    in0 = 8'h55;
    cyc(2);
    rdchk("mixed_rd", 0, 3'd0, 32'h0000_00A5);

    // Edge latency
    in0 = 8'h00;
    cyc(3);
    wr(0, 3'd3, 32'hFF);
    wr(0, 3'd2, 32'h02);
    addr = 3'd3; in0 = 8'h02;
    cyc(); chk("lat_e1_irq", {31'h0, irq0}, 32'h0); chk("lat_e1_ec", rd0, 32'h0);
    cyc(); chk("lat_e2_irq", {31'h0, irq0}, 32'h0); chk("lat_e2_ec", rd0, 32'h0);
    cyc(); chk("lat_e3_irq", {31'h0, irq0}, 32'h1); chk("lat_e3_ec", rd0, 32'h2);
    wr(0, 3'd3, 32'h02);
    addr = 3'd3; in0 = 8'h00;
    cyc(4);
    chk("fall_ec",  rd0, 32'h0);
    chk("fall_irq", {31'h0, irq0}, 32'h0);

    // W1C collides with a new rising edge
    in0 = 8'h02; cyc(3);
    in0 = 8'h00; cyc(3);
    in0 = 8'h02; cyc(2);
    wr(0, 3'd3, 32'h02);
    rdchk("coll_ec", 0, 3'd3, 32'h2);
    chk("coll_irq", {31'h0, irq0}, 32'h1);
    wr(0, 3'd3, 32'h02);
    rdchk("w1c_ec", 0, 3'd3, 32'h0);
    chk("w1c_irq", {31'h0, irq0}, 32'h0);

    // 32-bit instance, any-edge capture
    wr(1, 3'd1, 32'hFFFF_FFFF);
    wr(1, 3'd0, 32'hFFFF_FFFF);
    rdchk("w32_data", 1, 3'd0, 32'hFFFF_FFFF);
    wr(1, 3'd3, 32'hFFFF_FFFF);
    in1 = 32'h8000_0000; cyc(3);
    rdchk("w32_rise", 1, 3'd3, 32'h8000_0000);
    wr(1, 3'd3, 32'h8000_0000);
    rdchk("w32_clr", 1, 3'd3, 32'h0);
    in1 = 32'h0; cyc(3);
    rdchk("w32_fall", 1, 3'd3, 32'h8000_0000);

    // Randomised traffic against the model
    for (int i = 0; i < 3000; i++) begin
      rst   = ($urandom_range(0, 199) == 0);
      cs0   = $urandom_range(0, 1) != 0;
      cs1   = $urandom_range(0, 1) != 0;
      wn    = $urandom_range(0, 2) == 0;
      addr  = 3'($urandom_range(0, 7));
      wdata = $urandom;
      if ($urandom_range(0, 3) == 0) in0 = 8'($urandom);
      if ($urandom_range(0, 3) == 0) in1 = $urandom;
      cyc();
    end
    rst = 1'b0; cs0 = 1'b0; cs1 = 1'b0; wn = 1'b1;

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
